// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: op encodings and op helpers.
// Used by mem_access_ctrl and mem_load_ext.
package mem_access_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] data;
    logic [31:0] pc;
  } mem_wb_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_LBU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SW) && (op <= OP_SB);
  endfunction

  function automatic logic is_aligned(
    input logic [3:0] op,
    input logic [1:0] lane
  );
    logic ok;
    case (op)
      OP_LW, OP_SW:         ok = (lane == 2'b00);
      OP_LH, OP_LHU, OP_SH: ok = ~lane[0];
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data extraction: picks the byte/half lane from the read word
// and sign- or zero-extends it to 32 bits.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = '0;
    case (op)
      OP_LW:   data = word;
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM stage: store merge into word writes, load extraction, MEM/WB register.
// Define MEM_ACCESS_TRACE_EN to print every data-memory write in simulation.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [4:0]        wreg_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              dm_wr_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [DATA_W-1:0] dm_wd_o,
  input  logic [DATA_W-1:0] dm_rd_i,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_wreg_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [ADDR_W-1:0] wb_pc_o,
  output logic              misalign_o
);

  logic [1:0]        lane;
  logic              live;
  logic              load;
  logic              store;
  logic              aligned;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] wb_next;

  assign lane    = addr_i[1:0];
  assign live    = valid_i & ~flush_i & ~rst;
  assign load    = is_load(op_i);
  assign store   = is_store(op_i);
  assign aligned = is_aligned(op_i, lane);

  assign dm_addr_o = {addr_i[ADDR_W-1:2], 2'b00};
  assign dm_wr_o   = live & store & aligned & ~stall_i;

  // Merge against the word currently in memory (read-modify-write)
  always_comb begin
    dm_wd_o = dm_rd_i;
    case (op_i)
      OP_SW: dm_wd_o = wdata_i;
      OP_SH: begin
        if (lane[1]) dm_wd_o[31:16] = wdata_i[15:0];
        else         dm_wd_o[15:0]  = wdata_i[15:0];
      end
      OP_SB: dm_wd_o[{lane, 3'b000} +: 8] = wdata_i[7:0];
      default: dm_wd_o = dm_rd_i;
    endcase
  end

  mem_load_ext u_ext (
    .op   (op_i),
    .lane (lane),
    .word (dm_rd_i),
    .data (ld_data)
  );

  always_comb begin
    wb_next = '0;
    if (op_i == OP_NONE)     wb_next = alu_i;
    else if (load & aligned) wb_next = ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_wreg_o  <= '0;
      wb_data_o  <= '0;
      wb_pc_o    <= '0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= live & ~aligned & ~stall_i;
      if (!stall_i) begin
        wb_valid_o <= live;
        wb_we_o    <= live & (load | (op_i == OP_NONE))
                      & aligned & (wreg_i != 5'd0);
        wb_wreg_o  <= wreg_i;
        wb_data_o  <= wb_next;
        wb_pc_o    <= pc_i;
      end
    end
  end

`ifdef MEM_ACCESS_TRACE_EN
  always @(posedge clk) begin
    if (dm_wr_o)
      $display("%d@%h: *%h <= %h", $time, pc_i, addr_i, dm_wd_o);
  end
`else
`endif

endmodule
